// File: rtl/interp_upsampler.sv
// Per-channel linear-interpolating upsampler: each accepted sample produces 2^os outputs
// stepping from that channel's previous sample to the new one.
module interp_upsampler #(
    parameter int W_CHAN    = 5,
    parameter int N_CHAN    = 8,
    parameter int W_DATA    = 18,
    parameter int W_OS      = 3,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48,
    parameter logic [W_WR_ADDR-1:0] UPS_OS_ADDR       = W_WR_ADDR'(32'h0020),
    parameter logic [W_WR_ADDR-1:0] UPS_CLR_RQST_ADDR = W_WR_ADDR'(32'h0021)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        dv_in,
    input  logic [W_CHAN-1:0]           chan_in,
    input  logic signed [W_DATA-1:0]    data_in,
    output logic                        rdy_out,
    input  logic                        wr_en,
    input  logic [W_WR_ADDR-1:0]        wr_addr,
    input  logic [W_WR_CHAN-1:0]        wr_chan,
    input  logic [W_WR_DATA-1:0]        wr_data,
    output logic                        dv_out,
    output logic [W_CHAN-1:0]           chan_out,
    output logic signed [W_DATA-1:0]    data_out,
    output logic                        drop_out
);

    localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int W_ACC = W_DATA + (1 << W_OS);
    localparam int W_CNT = 1 << W_OS;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t                   state, state_nxt;
    logic [W_CHAN-1:0]        chan_q;
    logic signed [W_DATA-1:0] data_q;
    logic [W_OS-1:0]          os_q;
    logic signed [W_DATA:0]   delta;
    logic signed [W_ACC-1:0]  acc;
    logic [W_CNT-1:0]         cnt;
    logic [N_CHAN-1:0]        clr_rqst;
    logic signed [W_DATA-1:0] prev_mem [N_CHAN];
    logic [W_OS-1:0]          os_mem [N_CHAN];

    logic                     chan_ok, wr_chan_ok, active_clr, wr_os_hit, wr_clr_hit;
    logic [W_IDX-1:0]         idx, wr_idx;
    logic signed [W_DATA-1:0] p_rd;
    logic [W_OS-1:0]          os_rd;
    logic [W_CNT-1:0]         last_cnt;
    logic signed [W_ACC-1:0]  delta_ext, acc_nxt, acc_shr;
    logic                     unused_bits;

    assign chan_ok    = chan_q < W_CHAN'(N_CHAN);
    assign idx        = chan_q[W_IDX-1:0];
    assign wr_chan_ok = wr_chan < W_WR_CHAN'(N_CHAN);
    assign wr_idx     = wr_chan[W_IDX-1:0];
    assign p_rd       = chan_ok ? prev_mem[idx] : '0;
    assign os_rd      = chan_ok ? os_mem[idx] : '0;
    assign active_clr = chan_ok && clr_rqst[idx];
    assign last_cnt   = (W_CNT'(1) << os_q) - W_CNT'(1);
    assign wr_os_hit  = wr_en && (wr_addr == UPS_OS_ADDR) && wr_chan_ok;
    assign wr_clr_hit = wr_en && (wr_addr == UPS_CLR_RQST_ADDR) && wr_data[0] && wr_chan_ok;

    // The accumulator holds p*2^os + k*delta; shifting back by os floors to the k-th step.
    assign delta_ext   = {{(W_ACC-W_DATA-1){delta[W_DATA]}}, delta};
    assign acc_nxt     = acc + delta_ext;
    assign acc_shr     = acc_nxt >>> os_q;
    assign unused_bits = ^{wr_data[W_WR_DATA-1:W_OS], acc_shr[W_ACC-1:W_DATA]};

    // Input handshake: a sample transfers on a clock edge where dv_in && rdy_out;
    // dv_in while rdy_out is low discards the sample and pulses drop_out.
    assign rdy_out = (state == IDLE) && !rst_in;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dv_in) state_nxt = LOAD;
            LOAD:    state_nxt = EMIT;
            EMIT:    if (cnt == last_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && active_clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            chan_q   <= '0;
            data_q   <= '0;
            os_q     <= '0;
            delta    <= '0;
            acc      <= '0;
            cnt      <= '0;
            clr_rqst <= '0;
            dv_out   <= 1'b0;
            chan_out <= '0;
            data_out <= '0;
            drop_out <= 1'b0;
            for (int i = 0; i < N_CHAN; i++) begin
                prev_mem[i] <= '0;
                os_mem[i]   <= '0;
            end
        end else begin
            state    <= state_nxt;
            drop_out <= dv_in && !rdy_out;
            dv_out   <= 1'b0;
            clr_rqst <= '0;
            if (wr_clr_hit) clr_rqst[wr_idx] <= 1'b1;
            if (wr_os_hit)  os_mem[wr_idx] <= wr_data[W_OS-1:0];
            case (state)
                IDLE: if (dv_in) begin
                    chan_q <= chan_in;
                    data_q <= data_in;
                end
                LOAD: begin
                    os_q  <= os_rd;
                    delta <= {data_q[W_DATA-1], data_q} - {p_rd[W_DATA-1], p_rd};
                    acc   <= {{(W_ACC-W_DATA){p_rd[W_DATA-1]}}, p_rd} <<< os_rd;
                    cnt   <= '0;
                    if (chan_ok) prev_mem[idx] <= data_q;
                end
                EMIT: if (!active_clr) begin
                    acc      <= acc_nxt;
                    data_out <= acc_shr[W_DATA-1:0];
                    dv_out   <= 1'b1;
                    chan_out <= chan_q;
                    cnt      <= cnt + W_CNT'(1);
                end
                default: ;
            endcase
            // Placed after the LOAD write so a clear of the active channel wins.
            for (int i = 0; i < N_CHAN; i++)
                if (clr_rqst[i]) prev_mem[i] <= '0;
        end
    end

endmodule
